// File: rtl/vga_pkg.sv
// Shared VGA game constants and types; includes the jump controller's
// physics constants and the fall-speed helper.
package vga_pkg;

  localparam int unsigned YPOS_W     = 11;
  localparam int unsigned VEL_W      = 7;

  localparam int unsigned GROUNDLVL  = 480;
  localparam int unsigned Rect_hight = 10;

  localparam int unsigned GROUND_Y   = GROUNDLVL - Rect_hight;
  localparam int unsigned Y_MIN      = 0;
  localparam int unsigned JUMP_V     = 16;
  localparam int unsigned GRAVITY    = 1;
  localparam int unsigned V_MAX      = 16;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } jump_state_t;

  // Falling speed after one frame of gravity, saturated at v_max.
  function automatic logic [VEL_W-1:0] fall_speed(input logic [VEL_W-1:0] v,
                                                  input int unsigned    gravity,
                                                  input int unsigned    v_max);
    logic [VEL_W:0] s;
    s = {1'b0, v} + (VEL_W+1)'(gravity);
    if (s > (VEL_W+1)'(v_max)) s = (VEL_W+1)'(v_max);
    return s[VEL_W-1:0];
  endfunction

endpackage

// File: rtl/rect_jump_ctl.sv
// Per-frame vertical motion of the player rectangle: takeoff on a button
// edge, decelerating rise, gravity fall with speed cap, landing pulse.
module rect_jump_ctl
  import vga_pkg::*;
#(
  parameter int unsigned GROUND_Y = vga_pkg::GROUND_Y,
  parameter int unsigned Y_MIN    = vga_pkg::Y_MIN,
  parameter int unsigned JUMP_V   = vga_pkg::JUMP_V,
  parameter int unsigned GRAVITY  = vga_pkg::GRAVITY,
  parameter int unsigned V_MAX    = vga_pkg::V_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_tick,
  input  logic              enable,
  input  logic              jump_btn,
  output logic [YPOS_W-1:0] ypos,
  output logic              airborne,
  output logic              landed,
  output logic [1:0]        state
);

  localparam logic [1:0] ST_GROUND = GROUND;
  localparam logic [1:0] ST_RISE   = RISE;
  localparam logic [1:0] ST_FALL   = FALL;

  localparam int unsigned EXT_W = YPOS_W + 1;

  logic [1:0]        r_state;
  logic [YPOS_W-1:0] r_ypos;
  logic [VEL_W-1:0]  r_v;
  logic              r_pending;
  logic              r_btn_prev;
  logic              r_airborne;
  logic              r_landed;

  logic              w_tick;
  logic              w_btn_edge;
  logic              w_go;
  logic [VEL_W-1:0]  w_vn;
  logic [EXT_W-1:0]  w_yn;
  logic              w_ceil_hit;

  logic [1:0]        w_state_nx;
  logic [YPOS_W-1:0] w_ypos_nx;
  logic [VEL_W-1:0]  w_v_nx;
  logic              w_landed_nx;

  assign w_tick     = frame_tick & enable;
  assign w_btn_edge = jump_btn & ~r_btn_prev;
  // An edge arriving on the tick cycle itself still launches the jump.
  assign w_go       = r_pending | w_btn_edge;

  assign w_vn       = fall_speed(r_v, GRAVITY, V_MAX);
  assign w_yn       = EXT_W'(r_ypos) + EXT_W'(w_vn);
  assign w_ceil_hit = EXT_W'(r_ypos) < (EXT_W'(Y_MIN) + EXT_W'(r_v));

  // Next-state and next-position logic, evaluated only on an enabled tick.
  always_comb begin
    w_state_nx  = r_state;
    w_ypos_nx   = r_ypos;
    w_v_nx      = r_v;
    w_landed_nx = 1'b0;
    if (w_tick) begin
      case (r_state)
        ST_GROUND: begin
          if (w_go) begin
            w_state_nx = ST_RISE;
            w_v_nx     = VEL_W'(JUMP_V);
          end
        end
        ST_RISE: begin
          if (w_ceil_hit) begin
            w_ypos_nx  = YPOS_W'(Y_MIN);
            w_v_nx     = '0;
            w_state_nx = ST_FALL;
          end else begin
            w_ypos_nx = r_ypos - YPOS_W'(r_v);
            if (r_v <= VEL_W'(GRAVITY)) begin
              w_v_nx     = '0;
              w_state_nx = ST_FALL;
            end else begin
              w_v_nx = r_v - VEL_W'(GRAVITY);
            end
          end
        end
        ST_FALL: begin
          if (w_yn >= EXT_W'(GROUND_Y)) begin
            w_ypos_nx   = YPOS_W'(GROUND_Y);
            w_v_nx      = '0;
            w_state_nx  = ST_GROUND;
            w_landed_nx = 1'b1;
          end else begin
            w_ypos_nx = w_yn[YPOS_W-1:0];
            w_v_nx    = w_vn;
          end
        end
        default: begin
          w_state_nx = ST_GROUND;
          w_ypos_nx  = YPOS_W'(GROUND_Y);
          w_v_nx     = '0;
        end
      endcase
    end
  end

  // Pending request is consumed by every tick, airborne or not.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_GROUND;
      r_ypos     <= YPOS_W'(GROUND_Y);
      r_v        <= '0;
      r_pending  <= 1'b0;
      r_btn_prev <= 1'b0;
      r_airborne <= 1'b0;
      r_landed   <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_ypos     <= w_ypos_nx;
      r_v        <= w_v_nx;
      r_btn_prev <= jump_btn;
      r_airborne <= (w_state_nx != ST_GROUND);
      r_landed   <= w_landed_nx;
      if (w_tick)          r_pending <= 1'b0;
      else if (w_btn_edge) r_pending <= 1'b1;
    end
  end

  assign ypos     = r_ypos;
  assign state    = r_state;
  assign airborne = r_airborne;
  assign landed   = r_landed;

endmodule
